// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: single-clock oversampling UART receiver with majority voting and framing checks.
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1) after the data.
module uart_rx_cfg #(
    parameter int CLOCK_RATE = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frameErr,
    output logic                 parityErr
);
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t               r_state, w_next;
    logic [1:0]           r_sync, r_smp;
    logic                 r_prev, r_ferr;
    logic [DW-1:0]        r_div;
    logic [OW-1:0]        r_tick;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_rx, w_edge, w_tick, w_dec, w_maj, w_done;

    assign w_rx   = r_sync[1];
    assign w_edge = en & r_prev & ~w_rx;
    assign w_tick = r_div == DW'(DIV - 1);
    assign w_dec  = w_tick && r_tick == OW'(MID + 1);
    assign w_maj  = (r_smp[0] & r_smp[1]) | (w_rx & (r_smp[0] | r_smp[1]));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {r_sync, r_prev} <= '1;
        else {r_sync, r_prev} <= {r_sync[0], in, r_sync[1]};

    // Tick phase is held at zero while idle so it aligns to the detected start edge.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= '0;
            r_smp  <= '1;
        end else if (r_state == S_IDLE) begin
            r_div  <= '0;
            r_tick <= '0;
        end else begin
            r_div  <= w_tick ? '0 : r_div + 1'b1;
            r_tick <= !w_tick ? r_tick : r_tick == OW'(OVERSAMPLE - 1) ? '0 : r_tick + 1'b1;
            if (w_tick && r_tick == OW'(MID - 1)) r_smp[0] <= w_rx;
            if (w_tick && r_tick == OW'(MID)) r_smp[1] <= w_rx;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_edge ? S_START : S_IDLE;
            S_START:  if (w_dec) w_next = w_maj ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_dec && r_bit == 4'(DATA_BITS - 1)) w_next = S_PARITY;
            S_PARITY: if (w_dec) w_next = S_STOP;
`else
            S_DATA:   if (w_dec && r_bit == 4'(DATA_BITS - 1)) w_next = S_STOP;
`endif
            S_STOP:   if (w_dec && r_bit == 4'(STOP_BITS - 1)) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (!en) w_next = S_IDLE;
    end

    always_comb begin
        busy   = r_state != S_IDLE;
        w_done = en && r_state == S_STOP && w_next == S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_bit    <= '0;
            r_shift  <= '0;
            r_ferr   <= 1'b0;
            out      <= '0;
            valid    <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            r_bit  <= w_next != r_state ? '0 : r_bit + 4'(w_dec);
            r_ferr <= r_state == S_STOP && (r_ferr || (w_dec && !w_maj));
            valid  <= w_done;
            if (r_state == S_DATA && w_dec) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (w_done) begin
                out      <= r_shift;
                frameErr <= r_ferr | ~w_maj;
            end
        end

`ifdef UART_RX_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_perr    <= 1'b0;
            parityErr <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_dec) r_perr <= w_maj ^ (^r_shift) ^ PARITY_ODD[0];
            if (w_done) parityErr <= r_perr;
        end
`else
    logic w_unused;
    assign w_unused  = PARITY_ODD[0];
    assign parityErr = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames into an 8N1 receiver and a 5-data/2-stop receiver,
// checked every cycle against a frame-level model of what each line should deliver.
module tb_uart_rx_cfg;
    localparam int BIT = 434;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam bit ODD = 1'b0;

    typedef struct {
        int         ch;
        logic [8:0] data;
        logic       fe;
        logic       pe;
        longint     t;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, line0 = 1'b1, line1 = 1'b1;
    logic [7:0] out0;
    logic [4:0] out1;
    logic       valid0, busy0, fe0, pe0, valid1, busy1, fe1, pe1;
    logic [8:0] a_out[2], h_out[2];
    logic       a_valid[2], a_busy[2], a_fe[2], a_pe[2], h_fe[2], h_pe[2];
    exp_t       q[$];
    longint     cyc = 0;
    int         vec = 0, errs = 0;

    uart_rx_cfg dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(line0), .out(out0),
        .valid(valid0), .busy(busy0), .frameErr(fe0), .parityErr(pe0)
    );

    uart_rx_cfg #(.DATA_BITS(5), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .in(line1), .out(out1),
        .valid(valid1), .busy(busy1), .frameErr(fe1), .parityErr(pe1)
    );

    assign a_out[0]   = {1'b0, out0};
    assign a_out[1]   = {4'b0, out1};
    assign a_valid[0] = valid0;
    assign a_valid[1] = valid1;
    assign a_busy[0]  = busy0;
    assign a_busy[1]  = busy1;
    assign a_fe[0]    = fe0;
    assign a_fe[1]    = fe1;
    assign a_pe[0]    = pe0;
    assign a_pe[1]    = pe1;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nd(int c);
        return c ? 5 : 8;
    endfunction

    function automatic int ns(int c);
        return c ? 2 : 1;
    endfunction

    function automatic int nbits(int c);
        return 1 + nd(c) + P + ns(c);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line image of a frame: bit i is the level during bit time i.
    task automatic build(int c, logic [8:0] d, bit bad_stop, bit bad_par, output logic [15:0] b);
        int   k;
        logic par;
        b    = '1;
        b[0] = 1'b0;
        par  = ODD ^ bad_par;
        for (int i = 0; i < nd(c); i++) begin
            b[1+i] = d[i];
            par    = par ^ d[i];
        end
        k        = 1 + nd(c);
        b[k]     = par;
        b[k + P] = ~bad_stop;
    endtask

    // What a receiver must report for a given line image.
    task automatic push_exp(int c, logic [15:0] b);
        exp_t e;
        logic need;
        e.ch   = c;
        e.data = '0;
        e.fe   = 1'b0;
        e.t    = cyc;
        need   = ODD;
        for (int i = 0; i < nd(c); i++) begin
            e.data[i] = b[1+i];
            need      = need ^ b[1+i];
        end
        e.pe = P ? b[1 + nd(c)] != need : 1'b0;
        for (int i = 0; i < ns(c); i++)
            if (!b[1 + nd(c) + P + i]) e.fe = 1'b1;
        q.push_back(e);
    endtask

    task automatic drive(int c, logic [15:0] b, int n);
        for (int i = 0; i < n; i++) begin
            if (c == 0) line0 = b[i];
            else line1 = b[i];
            wait_clk(BIT);
        end
    endtask

    task automatic send(int c, logic [8:0] d, bit bad_stop, bit bad_par);
        logic [15:0] b;
        build(c, d, bad_stop, bad_par, b);
        push_exp(c, b);
        drive(c, b, nbits(c));
    endtask

    always @(negedge clk) begin
        exp_t   e;
        longint el, lo, hi;
        for (int c = 0; c < 2; c++) begin
            if (!rst_n) begin
                h_out[c] = '0;
                h_fe[c]  = 1'b0;
                h_pe[c]  = 1'b0;
                check("reset_valid_busy", {a_valid[c], a_busy[c]}, 0);
            end else if (a_valid[c]) begin
                vec++;
                if (q.size() == 0 || q[0].ch != c) begin
                    errs++;
                    $display("FAIL spurious_valid ch%0d: got valid=1, required valid=0 (cycle %0d)", c, cyc);
                end else begin
                    e        = q.pop_front();
                    h_out[c] = e.data;
                    h_fe[c]  = e.fe;
                    h_pe[c]  = e.pe;
                    check("busy_at_valid", a_busy[c], 0);
                    el = cyc - e.t;
                    lo = (2 * nbits(c) - 1) * BIT / 2 - BIT / 4;
                    hi = lo + BIT / 2;
                    vec++;
                    if (el < lo || el > hi) begin
                        errs++;
                        $display("FAIL valid_latency ch%0d: got %0d cycles, required %0d..%0d", c, el, lo, hi);
                    end
                end
            end
            check($sformatf("outputs_ch%0d", c), {a_out[c], a_fe[c], a_pe[c]}, {h_out[c], h_fe[c], h_pe[c]});
        end
    end

    initial begin
        logic [15:0] b;
        int          rise, fall;
        wait_clk(5);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);
        check("rst_busy0", busy0, 0);
        check("rst_flags0", {fe0, pe0, valid0}, 0);
        rst_n = 1'b1;
        wait_clk(BIT);

        send(0, 9'h14, 0, 0);
        check("f14_out", out0, 8'h14);
        check("f14_flags", {fe0, pe0}, 0);
        check("f14_busy", busy0, 0);
        check("f14_delivered", q.size(), 0);
`ifdef UART_RX_PARITY_EN
        send(0, 9'hA5, 0, 1);
        check("a5_badpar_out", out0, 8'hA5);
        check("a5_badpar_pe", pe0, 1);
        send(0, 9'hA5, 0, 0);
        check("a5_goodpar_pe", pe0, 0);
        check("a5_delivered", q.size(), 0);
`endif
        send(0, 9'h3C, 1, 0);
        check("3c_out", out0, 8'h3C);
        check("3c_fe", fe0, 1);
        line0 = 1'b1;
        wait_clk(BIT);
        send(0, 9'h55, 0, 0);
        check("55_out", out0, 8'h55);
        check("55_fe", fe0, 0);
        check("55_delivered", q.size(), 0);
        wait_clk(BIT);

        rise  = -1;
        fall  = -1;
        line0 = 1'b0;
        for (int i = 1; i <= BIT; i++) begin
            wait_clk(1);
            if (i == 100) line0 = 1'b1;
            if (busy0 && rise < 0) rise = i;
            if (!busy0 && rise >= 0 && fall < 0) fall = i;
        end
        check("glitch_busy_rise", rise, 3);
        check("glitch_busy_dropped", fall > 0 && fall < BIT, 1);
        check("glitch_out_kept", out0, 8'h55);
        wait_clk(BIT);

        build(0, 9'hA3, 0, 0, b);
        drive(0, b, 5);
        line0 = b[5];
        wait_clk(BIT / 2);
        check("midframe_busy", busy0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out0", out0, 0);
        check("midrst_busy0", busy0, 0);
        check("midrst_flags0", {fe0, pe0, valid0}, 0);
        line0 = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(BIT);
        send(0, 9'hFF, 0, 0);
        check("ff_out", out0, 8'hFF);
        check("ff_delivered", q.size(), 0);
        wait_clk(BIT);

        build(0, 9'h5A, 0, 0, b);
        drive(0, b, 4);
        line0 = b[4];
        wait_clk(BIT / 2);
        check("abort_busy_before", busy0, 1);
        en = 1'b0;
        wait_clk(1);
        check("abort_busy_after", busy0, 0);
        wait_clk(BIT / 2 - 1);
        for (int i = 5; i < nbits(0); i++) begin
            line0 = b[i];
            wait_clk(BIT);
        end
        check("abort_busy_en_low", busy0, 0);
        line0 = 1'b1;
        wait_clk(BIT);
        en = 1'b1;
        wait_clk(BIT);
        check("abort_out_kept", out0, 8'hFF);
        check("abort_fe_kept", fe0, 0);

        b = '0;
        push_exp(0, b);
        line0 = 1'b0;
        wait_clk(BIT * (nbits(0) + 3));
        check("break_out", out0, 0);
        check("break_fe", fe0, 1);
        check("break_delivered", q.size(), 0);
        line0 = 1'b1;
        wait_clk(BIT);

        send(1, 9'h1F, 0, 0);
        check("b2b_1f_out", out1, 5'h1F);
        send(1, 9'h00, 0, 0);
        check("b2b_00_out", out1, 5'h00);
        send(1, 9'h15, 0, 0);
        check("b2b_15_out", out1, 5'h15);
        check("b2b_flags", {fe1, pe1}, 0);
        check("b2b_delivered", q.size(), 0);
        wait_clk(BIT);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, single-clock UART receiver; successor to the fixed 8N1 receiver that runs on a derived rxClk. Generates its own oversampling tick from the system clock. Configurable data width, stop bits and parity. Adds majority-vote sampling, false-start rejection, and framing/parity error reporting. Sits between the pad-side serial input and byte-consuming logic, alongside the existing transmitter.

## Interface
Parameters:
- CLOCK_RATE, 50000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- OVERSAMPLE, 16: ticks per bit; even, ≥8.
- DATA_BITS, 8: payload bits per frame, 5–9.
- STOP_BITS, 1: 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only with UART_RX_PARITY_EN.

Ports:
- clk in 1: system clock; all logic on rising edge.
- rst_n in 1: asynchronous, active-low reset.
- en in 1: receiver enable.
- in in 1: serial line, idle high, asynchronous to clk.
- out out DATA_BITS: last received payload, LSB = first bit on the line.
- valid out 1: one-cycle pulse when out/err flags update.
- busy out 1: high from accepted start edge until frame end.
- frameErr out 1: stop bit sampled low; qualified by valid.
- parityErr out 1: parity mismatch; qualified by valid.

## Operation
- Input path: 2-FF synchronizer on `in`, reset to 1. All logic uses the synchronized value.
- Tick generator:
  - DIV = CLOCK_RATE/(BAUD_RATE*OVERSAMPLE), integer truncation; DIV ≥ 1 required.
  - Counter free-runs while state ≠ IDLE and is cleared to 0 on start-edge detection, so the tick phase is aligned to the start bit.
  - Defaults: DIV = 27.
- Bit sampling: majority of 3 synchronized samples taken at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within each bit. The bit decision is made at tick OVERSAMPLE/2+1.
- FSM states:
  - IDLE: wait for a 1→0 transition of the synchronized input while en=1, then go to START.
  - START: at mid-bit, majority=1 → false start, return to IDLE (no valid, busy drops). Majority=0 → go to DATA.
  - DATA: shift DATA_BITS bits LSB-first. Then go to PARITY if compiled in, else STOP.
  - PARITY: compare the received bit against the XOR of the data, inverted when PARITY_ODD=1.
  - STOP: sample STOP_BITS stop bits; any low sample sets frameErr.
    - After the decision on the last stop bit: load out, set flags, pulse valid, go to IDLE.
    - frameErr, parityErr and out hold until the next valid.
- Back-to-back frames: the receiver returns to IDLE at mid-stop-bit, so a start edge at the next bit boundary is caught.
- en deasserted mid-frame: abort to IDLE on the next clk. No valid; out and flags unchanged.
- Break (line held low): produces a frame with out=0 and frameErr=1. No new start is detected until the line returns high.

## Timing
- Reset values: out=0, valid=0, busy=0, frameErr=0, parityErr=0, FSM=IDLE, synchronizer=1.
- Reset asserted mid-frame: all of the above apply immediately, with no valid pulse.
- Start detection: 2 cycles of synchronizer latency, plus 1 cycle to busy=1.
- valid latency: asserted 1 clk after the last stop-bit decision tick. That is about (1 + DATA_BITS + P + STOP_BITS − 0.5) bit times plus 3 clk after the line's start edge, where P = 1 if parity is compiled in.
- valid is high for exactly 1 clk. busy deasserts in the same cycle valid asserts.
- Tolerance: the sampling point stays within ±OVERSAMPLE/2−1 ticks of mid-bit across the frame. The design target is cumulative rate error ≤ 3% at defaults.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state is present, and the frame includes one parity bit after the data.
  - parityErr is driven as specified, using PARITY_ODD.
- Not defined:
  - No PARITY state; frame = start + DATA_BITS + STOP_BITS.
  - parityErr is tied to 0 and PARITY_ODD is ignored.

## Test plan
Defaults (50 MHz clk, 8680 ns bit), macro undefined unless stated.

- Frame 0x14 (line: 0,0,0,1,0,1,0,0,0,1) → one valid pulse, out=0x14, frameErr=0, parityErr=0, busy low afterwards.
- Macro defined, PARITY_ODD=0, byte 0xA5 with parity bit 1 (wrong) → valid, out=0xA5, parityErr=1. Repeat with parity bit 0 → parityErr=0.
- Byte 0x3C with stop bit driven 0 → valid, out=0x3C, frameErr=1. Following good frame 0x55 → frameErr=0.
- 2 µs low glitch on the idle line → no valid; busy pulses high then returns to 0 before 1 bit time.
- rst_n low at mid-bit 4 of a frame → all outputs 0 immediately, no valid. Next full frame 0xFF after release → out=0xFF.
- DATA_BITS=5, STOP_BITS=2, three back-to-back frames 0x1F, 0x00, 0x15 with no idle gap → three valid pulses with matching out, no errors.
